alu_seq_top: RTL and testbench
==============================

// Module: alu_seq_top
// PURPOSE
//  Clocked, parametrised successor of the combinational calculator top.
//  Latches two signed operands on a start pulse and computes add, sub, mul or div.
//  Mul and div run multi-cycle. A sequential double-dabble converts the result to BCD.
//  Feeds the existing LED bank and the bcd2seg display chain; busy/done handshake to the control FSM.
// PARAMETERS
//  WIDTH   6  operand width, two's complement; result is 2*WIDTH bits
//  DIGITS  4  BCD digits produced; 10**DIGITS must exceed 2**(2*WIDTH-1)
// PORTS
//  clk     in   1           single clock, rising edge
//  rst_n   in   1           asynchronous, active-low reset
//  start   in   1           request; sampled only in IDLE
//  func    in   2           00 add, 01 sub, 10 mul, 11 div; latched with start
//  a       in   WIDTH       operand A / dividend, signed
//  b       in   WIDTH       operand B / divisor, signed
//  busy    out  1           high from the cycle after start is accepted until done
//  done    out  1           one-cycle pulse; result/bcd/neg/err valid and held after
//  result  out  2*WIDTH     add/sub/mul: signed result; div: {quotient, remainder}
//  bcd     out  4*DIGITS    magnitude digits, most significant nibble = highest digit
//  neg     out  1           sign of the displayed value
//  err     out  1           divide error, valid with done
// BEHAVIOUR
//  Reset:
//   - Async rst_n low forces IDLE and busy=done=neg=err=0, result=0, bcd=0, even mid-operation.
//   - The next start after release proceeds normally.
//  FSM: IDLE -> CALC -> CONV -> DONE -> IDLE.
//   - IDLE: start=1 latches a, b, func -> CALC.
//   - Start is ignored in every other state; a/b/func changes after latch are ignored.
//   - CALC add/sub: 1 cycle; a, b sign-extended to 2*WIDTH, so there is never overflow.
//   - CALC mul: WIDTH cycles; shift-add on magnitudes, sign applied at end.
//   - CALC div: WIDTH cycles; restoring division on magnitudes, truncate toward zero.
//     Remainder takes the dividend's sign.
//   - result is registered at the last CALC cycle and is stable from CONV onward.
//   - CONV: 2*WIDTH cycles of double-dabble on |value|.
//     Value = result for add/sub/mul, the quotient field for div.
//     neg = sign of that value; neg=0 for a zero value.
//   - DONE: done=1 for exactly one cycle, busy drops in the same cycle, then -> IDLE.
//  Latency:
//   - done rises Tcalc+Tconv+1 cycles after the start-sampling edge.
//   - Tcalc = 1 (add/sub) or WIDTH (mul/div).
//   - Tconv = 2*WIDTH.
//  Outputs:
//   - Outputs from a completed operation hold until the next accepted start.
//   - At that start err clears; result/bcd/neg keep their old values until overwritten.
//  Errors:
//   - Div with b=0: quotient=0, remainder=a, err=1.
//   - Div -2**(WIDTH-1) / -1: quotient=-2**(WIDTH-1) (wrapped), remainder=0, err=1.
//   - err=0 for all other operations.
//  Boundaries:
//   - mul of -2**(WIDTH-1) * -2**(WIDTH-1) = +2**(2*WIDTH-2) fits and sets no err.
//   - Unused upper BCD digits read 0.
// CONFIGURATION
//  ALU_SEQ_BCD_EN:
//   - Defined: CONV state and double-dabble present, as above.
//   - Undefined: no converter logic; CALC -> DONE directly; Tconv=0; bcd=0 and neg=0 always.
//   - Ports are unchanged in both cases.
// TESTING (WIDTH=6, DIGITS=4, ALU_SEQ_BCD_EN defined)
//  1. add a=5, b=-3 -> done 14 cycles after start; result=12'h002, bcd=16'h0002, neg=0, err=0
//  2. mul a=-32, b=-32 -> done at 19; result=12'h400, bcd=16'h1024, neg=0
//     mul a=-32, b=31 -> result=12'hC20, bcd=16'h0992, neg=1
//  3. div a=-31, b=4 -> result={6'h39,6'h3D} (q=-7, r=-3), bcd=16'h0007, neg=1, err=0
//  4. div a=17, b=0 -> result={6'h00,6'h11}, err=1
//     div a=-32, b=-1 -> err=1, then add 1+1 -> err=0
//  5. start pulsed each cycle while busy -> exactly one done, first operands used
//     rst_n low in mid-CALC -> all outputs 0 at once; new start gives correct result
//  6. ALU_SEQ_BCD_EN undefined: add 5+(-3) -> done 2 cycles after start, bcd=0, neg=0

Source files
------------

// File: rtl/alu_seq_top_if.sv
// Request/response bundle between the control FSM and the sequential ALU.
// The master drives the operands and the start pulse. The slave returns the
// busy/done handshake, the binary result, and the BCD display fields.
interface alu_seq_top_if #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [1:0]            func;
   logic [WIDTH-1:0]      a;
   logic [WIDTH-1:0]      b;
   logic                  busy;
   logic                  done;
   logic [2*WIDTH-1:0]    result;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;
   logic                  err;

   modport master (output start, func, a, b,
                   input  busy, done, result, bcd, neg, err);
   modport slave  (input  start, func, a, b,
                   output busy, done, result, bcd, neg, err);
endinterface

// File: rtl/alu_seq_top.sv
// Sequential calculator: add/sub (1 cycle), shift-add mul and restoring div
// (WIDTH cycles each), then an optional double-dabble BCD conversion
// (2*WIDTH cycles) of the displayed value.
// Define ALU_SEQ_BCD_EN to build the converter. Without it, the FSM goes from
// CALC straight to DONE, and bcd/neg are tied to zero.
module alu_seq_top #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_top_if.slave  io
);
   localparam int RW = 2*WIDTH;
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(RW);
   localparam logic [CW-1:0] CALC_END = CW'(WIDTH-1);
`ifdef ALU_SEQ_BCD_EN
   localparam bit BCD_EN = 1'b1;
`else
   localparam bit BCD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt;
   logic              accept, calc_last, conv_last;
   logic              busy_q, done_q, busy_d, done_d;

   logic [WIDTH-1:0]  a_r, b_r, mag_b, mag_a_in, mag_b_in;
   logic [1:0]        func_r;
   logic              err_pend, err_q;
   logic [RW-1:0]     result_q, res_next;

   // shift-add multiplier and restoring divider state, both on magnitudes
   logic [RW-1:0]     p_acc, p_mcand, p_acc_n;
   logic [WIDTH-1:0]  p_mplr;
   logic [WIDTH-1:0]  d_rem, d_quo, d_rem_n, d_quo_n;
   logic [WIDTH:0]    d_sh, d_diff;
   logic              d_ge;

   assign accept    = (state == IDLE) && io.start;
   assign calc_last = (state == CALC) && (!func_r[1] || cnt == CALC_END);
   assign mag_a_in  = io.a[WIDTH-1] ? -io.a : io.a;
   assign mag_b_in  = io.b[WIDTH-1] ? -io.b : io.b;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (io.start) state_n = CALC;
         CALC:    if (calc_last) state_n = BCD_EN ? CONV : DONE;
         CONV:    if (conv_last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // handshake outputs; registered so done lands one cycle after DONE is entered
   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      case (state)
         IDLE:    if (io.start) busy_d = 1'b1;
         DONE:    begin busy_d = 1'b0; done_d = 1'b1; end
         default: ;
      endcase
   end

   // handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // per-state cycle counter, restarts on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              cnt <= '0;
      else if (state_n != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
   end

   // one mul/div iteration plus final sign fix-up of the result
   always_comb begin
      p_acc_n = p_mplr[0] ? p_acc + p_mcand : p_acc;
      d_sh    = {d_rem, d_quo[WIDTH-1]};
      d_diff  = d_sh - {1'b0, mag_b};
      d_ge    = ~d_diff[WIDTH];
      d_rem_n = d_ge ? d_diff[WIDTH-1:0] : d_sh[WIDTH-1:0];
      d_quo_n = {d_quo[WIDTH-2:0], d_ge};
      case (func_r)
         2'b00:   res_next = {{WIDTH{a_r[WIDTH-1]}}, a_r} + {{WIDTH{b_r[WIDTH-1]}}, b_r};
         2'b01:   res_next = {{WIDTH{a_r[WIDTH-1]}}, a_r} - {{WIDTH{b_r[WIDTH-1]}}, b_r};
         2'b10:   res_next = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -p_acc_n : p_acc_n;
         default: begin
            // a zero divisor yields q=0, r=a; -min/-1 wraps naturally
            if (b_r == '0) res_next = {{WIDTH{1'b0}}, a_r};
            else           res_next = {(a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -d_quo_n : d_quo_n,
                                       a_r[WIDTH-1] ? -d_rem_n : d_rem_n};
         end
      endcase
   end

   // operand latch, iteration registers, result and error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         func_r   <= '0;
         mag_b    <= '0;
         p_acc    <= '0;
         p_mcand  <= '0;
         p_mplr   <= '0;
         d_rem    <= '0;
         d_quo    <= '0;
         err_pend <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         a_r      <= io.a;
         b_r      <= io.b;
         func_r   <= io.func;
         mag_b    <= mag_b_in;
         p_acc    <= '0;
         p_mcand  <= {{WIDTH{1'b0}}, mag_a_in};
         p_mplr   <= mag_b_in;
         d_rem    <= '0;
         d_quo    <= mag_a_in;
         err_pend <= (io.func == 2'b11) &&
                     (io.b == '0 || (io.a == {1'b1, {(WIDTH-1){1'b0}}} && io.b == '1));
         err_q    <= 1'b0;
      end else if (state == CALC) begin
         p_acc   <= p_acc_n;
         p_mcand <= p_mcand << 1;
         p_mplr  <= p_mplr >> 1;
         d_rem   <= d_rem_n;
         d_quo   <= d_quo_n;
         if (calc_last) begin
            result_q <= res_next;
            err_q    <= err_pend;
         end
      end
   end

   assign io.busy   = busy_q;
   assign io.done   = done_q;
   assign io.result = result_q;
   assign io.err    = err_q;

`ifdef ALU_SEQ_BCD_EN
   localparam logic [CW-1:0] CONV_END = CW'(RW-1);

   logic [RW-1:0]            disp_val, disp_mag;
   logic                     disp_neg, conv_neg, neg_q;
   logic [BW+RW-1:0]         dd_sr, dd_adj, dd_next;
   logic [DIGITS-1:0][3:0]   dd_dig, dd_fix;
   logic [BW-1:0]            bcd_q;

   // div displays the quotient field; everything else shows the full result
   assign disp_val  = (func_r == 2'b11) ? {{WIDTH{res_next[RW-1]}}, res_next[RW-1:WIDTH]} : res_next;
   assign disp_neg  = disp_val[RW-1];
   assign disp_mag  = disp_neg ? -disp_val : disp_val;
   assign conv_last = (state == CONV) && (cnt == CONV_END);
   assign dd_dig    = dd_sr[BW+RW-1:RW];

   for (genvar gd = 0; gd < DIGITS; gd++) begin : g_dig
      assign dd_fix[gd] = (dd_dig[gd] >= 4'd5) ? dd_dig[gd] + 4'd3 : dd_dig[gd];
   end

   assign dd_adj  = {dd_fix, dd_sr[RW-1:0]};
   assign dd_next = dd_adj << 1;

   // double-dabble shift register, loaded with |value| as CALC finishes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dd_sr    <= '0;
         conv_neg <= 1'b0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
      end else if (calc_last) begin
         dd_sr    <= {{BW{1'b0}}, disp_mag};
         conv_neg <= disp_neg;
      end else if (state == CONV) begin
         dd_sr <= dd_next;
         if (conv_last) begin
            bcd_q <= dd_next[BW+RW-1:RW];
            neg_q <= conv_neg;
         end
      end
   end

   assign io.bcd = bcd_q;
   assign io.neg = neg_q;
`else
   assign conv_last = 1'b0;
   assign io.bcd    = '0;
   assign io.neg    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq_top.sv
// Scoreboard bench for alu_seq_top. Expected values come from integer
// arithmetic. The BCD expectations follow ALU_SEQ_BCD_EN.
module tb_alu_seq_top;
   localparam int W = 6;
   localparam int D = 4;
`ifdef ALU_SEQ_BCD_EN
   localparam bit BCD_EN = 1'b1;
`else
   localparam bit BCD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_top_if #(.WIDTH(W), .DIGITS(D)) io ();
   alu_seq_top #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .io(io));

   typedef struct {
      logic [2*W-1:0] res;
      logic [4*D-1:0] bcd;
      logic           neg;
      logic           err;
      int             lat;
      string          name;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   function automatic exp_t model(input int a, input int b, input logic [1:0] f, input string nm);
      exp_t e;
      int v, q, r, m;
      logic ng;
      e.err = 1'b0;
      e.name = nm;
      v = 0;
      case (f)
         2'd0: begin v = a + b; e.res = v[11:0]; end
         2'd1: begin v = a - b; e.res = v[11:0]; end
         2'd2: begin v = a * b; e.res = v[11:0]; end
         default: begin
            if (b == 0) begin q = 0; r = a; e.err = 1'b1; end
            else if (a == -32 && b == -1) begin q = -32; r = 0; e.err = 1'b1; end
            else begin q = a / b; r = a % b; end
            e.res = {q[5:0], r[5:0]};
            v = q;
         end
      endcase
      ng = (v < 0);
      m = ng ? -v : v;
      e.bcd = '0;
      for (int i = 0; i < D; i++) begin
         e.bcd[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      e.neg = ng;
      if (!BCD_EN) begin
         e.bcd = '0;
         e.neg = 1'b0;
      end
      e.lat = (f[1] ? W : 1) + (BCD_EN ? 2*W : 0) + 1;
      return e;
   endfunction

   task automatic issue(input int a, input int b, input logic [1:0] f, input string nm);
      sb.push_back(model(a, b, f, nm));
      io.a = W'(a);
      io.b = W'(b);
      io.func = f;
      io.start = 1'b1;
      @(posedge clk); #1;
      io.start = 1'b0;
      io.a = ~io.a;
      io.b = ~io.b;
      io.func = ~io.func;
      checks++;
      if (io.busy !== 1'b1) begin
         errors++;
         $display("FAIL %s.busy_after_start got %b exp 1", nm, io.busy);
      end
   endtask

   task automatic collect();
      exp_t e;
      int cyc;
      e = sb.pop_front();
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (io.done !== 1'b1 && cyc < 100);
      checks++;
      if (io.done !== 1'b1) begin
         errors++;
         $display("FAIL %s.timeout no done after %0d cycles", e.name, cyc);
         return;
      end
      if (cyc != e.lat) begin
         errors++;
         $display("FAIL %s.latency got %0d exp %0d", e.name, cyc, e.lat);
      end
      checks++;
      if (io.result !== e.res) begin
         errors++;
         $display("FAIL %s.result got %h exp %h", e.name, io.result, e.res);
      end
      checks++;
      if (io.bcd !== e.bcd) begin
         errors++;
         $display("FAIL %s.bcd got %h exp %h", e.name, io.bcd, e.bcd);
      end
      checks++;
      if (io.neg !== e.neg) begin
         errors++;
         $display("FAIL %s.neg got %b exp %b", e.name, io.neg, e.neg);
      end
      checks++;
      if (io.err !== e.err) begin
         errors++;
         $display("FAIL %s.err got %b exp %b", e.name, io.err, e.err);
      end
      checks++;
      if (io.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s.busy_at_done got %b exp 0", e.name, io.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (io.done !== 1'b0) begin
         errors++;
         $display("FAIL %s.done_width got %b exp 0", e.name, io.done);
      end
   endtask

   task automatic run_op(input int a, input int b, input logic [1:0] f, input string nm);
      issue(a, b, f, nm);
      collect();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      io.start = 1'b0;
      io.func = 2'b00;
      io.a = '0;
      io.b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({io.busy, io.done, io.neg, io.err} !== 4'b0) begin
         errors++;
         $display("FAIL reset.flags got %b exp 0000", {io.busy, io.done, io.neg, io.err});
      end
      checks++;
      if (io.result !== '0 || io.bcd !== '0) begin
         errors++;
         $display("FAIL reset.data got %h/%h exp 0/0", io.result, io.bcd);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_addsub();
      run_op(5, -3, 2'd0, "add");
      run_op(3, 20, 2'd1, "sub_neg");
      run_op(-32, -32, 2'd0, "add_min");
      run_op(31, -32, 2'd1, "sub_max");
   endtask

   task automatic test_mul();
      run_op(-32, -32, 2'd2, "mul_minmin");
      run_op(-32, 31, 2'd2, "mul_neg");
      run_op(0, -7, 2'd2, "mul_zero");
      run_op(7, -1, 2'd2, "mul_m1");
   endtask

   task automatic test_div();
      run_op(-31, 4, 2'd3, "div_neg");
      run_op(17, -5, 2'd3, "div_negb");
      run_op(5, 9, 2'd3, "div_small");
   endtask

   task automatic test_div_err();
      run_op(17, 0, 2'd3, "div_zero");
      run_op(-32, -1, 2'd3, "div_ovf");
      run_op(1, 1, 2'd0, "add_after_err");
   endtask

   task automatic test_hold();
      exp_t h;
      h = model(17, 0, 2'd3, "hold");
      run_op(17, 0, 2'd3, "hold_div");
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (io.err !== 1'b1 || io.result !== h.res) begin
         errors++;
         $display("FAIL hold.idle got err=%b res=%h exp err=1 res=%h", io.err, io.result, h.res);
      end
      issue(1, 1, 2'd0, "hold_add");
      checks++;
      if (io.err !== 1'b0) begin
         errors++;
         $display("FAIL hold.err_clear got %b exp 0", io.err);
      end
      checks++;
      if (io.result !== h.res) begin
         errors++;
         $display("FAIL hold.result_kept got %h exp %h", io.result, h.res);
      end
      collect();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int cyc, extra;
      e = model(2, 3, 2'd2, "b2b");
      io.a = W'(2);
      io.b = W'(3);
      io.func = 2'd2;
      io.start = 1'b1;
      @(posedge clk); #1;
      io.a = W'(9);
      io.b = W'(9);
      io.func = 2'd0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (io.done !== 1'b1 && cyc < 100);
      io.start = 1'b0;
      checks++;
      if (io.done !== 1'b1 || cyc != e.lat) begin
         errors++;
         $display("FAIL b2b.latency got %0d exp %0d (done=%b)", cyc, e.lat, io.done);
      end
      checks++;
      if (io.result !== e.res) begin
         errors++;
         $display("FAIL b2b.result got %h exp %h", io.result, e.res);
      end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (io.done === 1'b1 || io.busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL b2b.extra_activity got %0d cycles exp 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      issue(-20, 13, 2'd2, "rst_mid");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({io.busy, io.done, io.neg, io.err, io.result, io.bcd} !== '0) begin
         errors++;
         $display("FAIL rst_mid.outputs got busy=%b done=%b neg=%b err=%b res=%h bcd=%h exp all 0",
                  io.busy, io.done, io.neg, io.err, io.result, io.bcd);
      end
      void'(sb.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(5, -3, 2'd0, "post_rst");
   endtask

   task automatic test_random();
      int a, b;
      logic [1:0] f;
      for (int i = 0; i < 12; i++) begin
         a = int'($urandom_range(63)) - 32;
         b = int'($urandom_range(63)) - 32;
         f = 2'($urandom_range(3));
         run_op(a, b, f, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_mul();
      test_div();
      test_div_err();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
